// File: rtl/led_shift_sequencer_if.sv
// Strobe/status bundle between the sequencer and the colour-component chain.
interface led_shift_sequencer_if;
  logic       enable;
  logic       bright_req;
  logic [7:0] pwm_time;
  logic       load_led_vals;
  logic       load_brightness;
  logic       shift;
  logic       sclk;
  logic       latch;
  logic       bright_mode;
  logic       frame_start;
  logic       busy;

  // Sequencer side: consumes the run controls, drives time base and strobes.
  modport master (
    input  enable,
    input  bright_req,
    output pwm_time,
    output load_led_vals,
    output load_brightness,
    output shift,
    output sclk,
    output latch,
    output bright_mode,
    output frame_start,
    output busy
  );

  // Chain/controller side: drives the run controls, observes the strobes.
  modport slave (
    output enable,
    output bright_req,
    input  pwm_time,
    input  load_led_vals,
    input  load_brightness,
    input  shift,
    input  sclk,
    input  latch,
    input  bright_mode,
    input  frame_start,
    input  busy
  );
endinterface

// File: rtl/led_shift_sequencer.sv
// Timing master for the colour-component serial chain: PWM time base plus
// load/shift/latch strobes and the LED-driver sclk/latch/bright_mode lines.
module led_shift_sequencer #(
  parameter int unsigned SHIFT_BITS   = 16,
  parameter int unsigned SCLK_HALF    = 2,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_shift_sequencer_if.master bus
);

  localparam int unsigned PH_MAX = (SCLK_HALF > LATCH_CYCLES) ? SCLK_HALF : LATCH_CYCLES;
  localparam int unsigned CNT_W  = $clog2(PH_MAX) + 1;
  localparam int unsigned BIT_W  = $clog2(SHIFT_BITS) + 1;
  localparam int unsigned PWM_W  = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4,
    NEXT     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PWM_W-1:0]   pwm_time_q, pwm_time_d;
  logic               bright_pend_q, bright_pend_d;
  logic               bright_word_q, bright_word_d;
  logic               load_led_vals_q, load_led_vals_d;
  logic               load_brightness_q, load_brightness_d;
  logic               shift_q, shift_d;
  logic               sclk_q, sclk_d;
  logic               latch_q, latch_d;
  logic               bright_mode_q, bright_mode_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      bit_q             <= '0;
      pwm_time_q        <= '0;
      bright_pend_q     <= 1'b1;
      bright_word_q     <= 1'b0;
      load_led_vals_q   <= 1'b0;
      load_brightness_q <= 1'b0;
      shift_q           <= 1'b0;
      sclk_q            <= 1'b0;
      latch_q           <= 1'b0;
      bright_mode_q     <= 1'b0;
      frame_start_q     <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      bit_q             <= bit_d;
      pwm_time_q        <= pwm_time_d;
      bright_pend_q     <= bright_pend_d;
      bright_word_q     <= bright_word_d;
      load_led_vals_q   <= load_led_vals_d;
      load_brightness_q <= load_brightness_d;
      shift_q           <= shift_d;
      sclk_q            <= sclk_d;
      latch_q           <= latch_d;
      bright_mode_q     <= bright_mode_d;
      frame_start_q     <= frame_start_d;
      busy_q            <= busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    bit_d         = bit_q;
    pwm_time_d    = pwm_time_q;
    bright_word_d = bright_word_q;
    frame_start_d = 1'b0;

    // A request set in the same cycle as the brightness load stays pending.
    bright_pend_d = bright_pend_q;
    if (state_q == LOAD && bright_word_q) bright_pend_d = 1'b0;
    if (bus.bright_req)                   bright_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT_LO;
        bit_d   = '0;
      end
      SHIFT_LO: begin
        if (cnt_q == CNT_W'(SCLK_HALF - 1)) state_d = SHIFT_HI;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      SHIFT_HI: begin
        if (cnt_q == CNT_W'(SCLK_HALF - 1)) begin
          if (bit_q < BIT_W'(SHIFT_BITS - 1)) begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          state_d = NEXT;
          // Time base advances on entry to NEXT so frame_start aligns with pwm_time=0.
          if (!bright_word_q) begin
            pwm_time_d    = pwm_time_q + PWM_W'(1);
            frame_start_d = (pwm_time_q == PWM_W'(255));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEXT: begin
        state_d = bus.enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Word type is fixed on entry to LOAD; bright_word_q still holds the previous word.
    if (state_d == LOAD)
      bright_word_d = bright_pend_q && (pwm_time_q == '0) && !bright_word_q;

    load_led_vals_d   = (state_d == LOAD) && !bright_word_d;
    load_brightness_d = (state_d == LOAD) &&  bright_word_d;
    sclk_d            = (state_d == SHIFT_HI);
    shift_d           = (state_d == SHIFT_HI) && (cnt_d == CNT_W'(SCLK_HALF - 1));
    latch_d           = (state_d == LATCH);
    bright_mode_d     = bright_word_d &&
                        (state_d inside {LOAD, SHIFT_LO, SHIFT_HI, LATCH});
    busy_d            = (state_d != IDLE);
  end

  assign bus.pwm_time        = pwm_time_q;
  assign bus.load_led_vals   = load_led_vals_q;
  assign bus.load_brightness = load_brightness_q;
  assign bus.shift           = shift_q;
  assign bus.sclk            = sclk_q;
  assign bus.latch           = latch_q;
  assign bus.bright_mode     = bright_mode_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench: default build (a) for word/frame behaviour, SCLK_HALF=1 build (b) for reset mid-word.
module tb_led_shift_sequencer;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  led_shift_sequencer_if ifa();
  led_shift_sequencer_if ifb();

  led_shift_sequencer u_dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (ifa)
  );

  led_shift_sequencer #(
    .SHIFT_BITS   (16),
    .SCLK_HALF    (1),
    .LATCH_CYCLES (2)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       bright;
    logic       mode;
    logic [7:0] pwm;
    int         len;
    int         shifts;
    int         rises;
    int         latch;
    int         bad;
    int         fs;
  } word_t;

  word_t q[$];

  int cyc       = 0;
  int last_load = 0;
  int cur_shifts, cur_rises, cur_latch, cur_bad, cur_fs;
  int excl_err  = 0;
  logic sclk_prev = 1'b0;

  // Word monitor for build (a): one record per LOAD, carrying the stats of the preceding word.
  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (ifa.load_led_vals && (ifa.load_brightness || ifa.bright_mode)) excl_err++;
    if (ifa.load_led_vals || ifa.load_brightness) begin
      w.bright = ifa.load_brightness;
      w.mode   = ifa.bright_mode;
      w.pwm    = ifa.pwm_time;
      w.len    = cyc - last_load;
      w.shifts = cur_shifts;
      w.rises  = cur_rises;
      w.latch  = cur_latch;
      w.bad    = cur_bad;
      w.fs     = cur_fs;
      q.push_back(w);
      last_load  = cyc;
      cur_shifts = 0;
      cur_rises  = 0;
      cur_latch  = 0;
      cur_bad    = 0;
      cur_fs     = 0;
    end
    if (ifa.shift) cur_shifts++;
    if (ifa.sclk && !sclk_prev) cur_rises++;
    if (ifa.latch) cur_latch++;
    if (ifa.shift && !ifa.sclk) cur_bad++;
    if (ifa.frame_start) cur_fs++;
    sclk_prev = ifa.sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_word(output word_t w);
    int n = 0;
    while (q.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    if (q.size() == 0) begin
      check_eq("word_timeout", 32'd1, 32'd0);
      w = '{default: 0};
    end else begin
      w = q.pop_front();
    end
  endtask

  function automatic logic [15:0] outs_a();
    return {ifa.pwm_time, ifa.load_led_vals, ifa.load_brightness, ifa.shift, ifa.sclk,
            ifa.latch, ifa.bright_mode, ifa.frame_start, ifa.busy};
  endfunction

  function automatic logic [15:0] outs_b();
    return {ifb.pwm_time, ifb.load_led_vals, ifb.load_brightness, ifb.shift, ifb.sclk,
            ifb.latch, ifb.bright_mode, ifb.frame_start, ifb.busy};
  endfunction

  task automatic wait_b_load(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ifb.load_led_vals || ifb.load_brightness) && n < 200);
    if (n >= 200) check_eq("b_load_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    word_t w;
    int    exp_pwm, err_pwm, err_br, err_fs, err_len, fs_sum, n;

    rst_a_n        = 1'b0;
    rst_b_n        = 1'b0;
    ifa.enable     = 1'b0;
    ifa.bright_req = 1'b0;
    ifb.enable     = 1'b0;
    ifb.bright_req = 1'b0;
    repeat (3) tick();
    check_eq("a_reset_outs", 32'(outs_a()), 32'd0);
    rst_a_n = 1'b1;
    repeat (3) tick();
    check_eq("a_idle_outs", 32'(outs_a()), 32'd0);

    // Start-up: brightness word, then data pwm 0, then data pwm 1.
    ifa.enable = 1'b1;
    get_word(w);
    check_eq("w0_bright", 32'(w.bright), 32'd1);
    check_eq("w0_mode",   32'(w.mode),   32'd1);
    check_eq("w0_pwm",    32'(w.pwm),    32'd0);
    get_word(w);
    check_eq("w1_bright", 32'(w.bright), 32'd0);
    check_eq("w1_pwm",    32'(w.pwm),    32'd0);
    check_eq("w0_len",    32'(w.len),    32'd68);
    check_eq("w0_shifts", 32'(w.shifts), 32'd16);
    get_word(w);
    check_eq("w2_bright", 32'(w.bright), 32'd0);
    check_eq("w2_pwm",    32'(w.pwm),    32'd1);
    check_eq("w1_len",    32'(w.len),    32'd68);
    check_eq("w1_shifts", 32'(w.shifts), 32'd16);
    check_eq("w1_rises",  32'(w.rises),  32'd16);
    check_eq("w1_latch",  32'(w.latch),  32'd2);
    check_eq("w1_shift_in_lo", 32'(w.bad), 32'd0);

    // Full frame: 256 data words, single frame_start at the wrap, no brightness word.
    exp_pwm = 1; err_pwm = 0; err_br = 0; err_fs = 0; err_len = 0; fs_sum = 0;
    for (int i = 0; i < 256; i++) begin
      get_word(w);
      exp_pwm = (exp_pwm + 1) % 256;
      if (int'(w.pwm) != exp_pwm) err_pwm++;
      if (w.bright) err_br++;
      if (w.len != 68 || w.shifts != 16 || w.rises != 16 || w.latch != 2 || w.bad != 0) err_len++;
      if (w.fs != ((exp_pwm == 0) ? 1 : 0)) err_fs++;
      fs_sum += w.fs;
    end
    check_eq("frame_pwm_seq_errs",   32'(err_pwm), 32'd0);
    check_eq("frame_bright_words",   32'(err_br),  32'd0);
    check_eq("frame_word_shape_errs", 32'(err_len), 32'd0);
    check_eq("frame_fs_place_errs",  32'(err_fs),  32'd0);
    check_eq("frame_fs_total",       32'(fs_sum),  32'd1);
    check_eq("frame_end_pwm",        32'(w.pwm),   32'd1);

    // Brightness request mid-frame is held until the wrap.
    n = 0;
    do begin get_word(w); n++; end while (w.pwm != 8'd100 && n < 200);
    check_eq("reach_pwm100", 32'(w.pwm), 32'd100);
    ifa.bright_req = 1'b1;
    tick();
    ifa.bright_req = 1'b0;
    err_pwm = 0; err_br = 0;
    for (int p = 101; p < 256; p++) begin
      get_word(w);
      if (int'(w.pwm) != p) err_pwm++;
      if (w.bright) err_br++;
    end
    check_eq("req_pwm_seq_errs",    32'(err_pwm), 32'd0);
    check_eq("req_early_bright",    32'(err_br),  32'd0);
    get_word(w);
    check_eq("req_bw_bright", 32'(w.bright), 32'd1);
    check_eq("req_bw_mode",   32'(w.mode),   32'd1);
    check_eq("req_bw_pwm",    32'(w.pwm),    32'd0);
    check_eq("req_bw_fs",     32'(w.fs),     32'd1);
    get_word(w);
    check_eq("req_d0_bright", 32'(w.bright), 32'd0);
    check_eq("req_d0_pwm",    32'(w.pwm),    32'd0);
    check_eq("req_d0_fs",     32'(w.fs),     32'd0);
    get_word(w);
    check_eq("req_d1_bright", 32'(w.bright), 32'd0);
    check_eq("req_d1_pwm",    32'(w.pwm),    32'd1);

    // Enable dropped during bit 7 of the pwm=5 word: word completes, then idle.
    n = 0;
    do begin get_word(w); n++; end while (w.pwm != 8'd5 && n < 20);
    check_eq("reach_pwm5", 32'(w.pwm), 32'd5);
    repeat (29) tick();
    ifa.enable = 1'b0;
    n = 0;
    while (ifa.busy && n < 100) begin tick(); n++; end
    check_eq("stop_busy",   32'(ifa.busy),     32'd0);
    check_eq("stop_pwm",    32'(ifa.pwm_time), 32'd6);
    check_eq("stop_shifts", 32'(cur_shifts),   32'd16);
    check_eq("stop_latch",  32'(cur_latch),    32'd2);
    repeat (10) tick();
    check_eq("idle_outs",   32'(outs_a()),     32'h0600);
    check_eq("idle_no_load", 32'(q.size()),    32'd0);
    ifa.enable = 1'b1;
    get_word(w);
    check_eq("resume_pwm",    32'(w.pwm),    32'd6);
    check_eq("resume_bright", 32'(w.bright), 32'd0);
    ifa.enable = 1'b0;
    check_eq("excl_violations", 32'(excl_err), 32'd0);

    // SCLK_HALF=1 build: word length, then async reset during LATCH.
    rst_b_n    = 1'b1;
    ifb.enable = 1'b1;
    wait_b_load(n);
    check_eq("b_first_bright", 32'(ifb.load_brightness), 32'd1);
    wait_b_load(n);
    check_eq("b_word_len",     32'(n), 32'd36);
    n = 0;
    while (!(ifb.latch && ifb.pwm_time == 8'd2) && n < 300) begin tick(); n++; end
    check_eq("b_reach_latch", 32'(ifb.latch), 32'd1);
    rst_b_n    = 1'b0;
    ifb.enable = 1'b0;
    #1;
    check_eq("b_reset_now", 32'(outs_b()), 32'd0);
    repeat (2) tick();
    rst_b_n = 1'b1;
    repeat (4) tick();
    check_eq("b_post_reset_idle", 32'(outs_b()), 32'd0);
    ifb.enable = 1'b1;
    wait_b_load(n);
    check_eq("b_restart_bright", 32'(ifb.load_brightness), 32'd1);
    check_eq("b_restart_mode",   32'(ifb.bright_mode),     32'd1);
    check_eq("b_restart_ll",     32'(ifb.load_led_vals),   32'd0);
    check_eq("b_restart_pwm",    32'(ifb.pwm_time),        32'd0);
    ifb.enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
